stream_serializer: RTL and testbench

Width-down converter for valid/ready streams. It accepts one wide word of `WIDTH*RATIO` bits and emits it as `RATIO` consecutive narrow beats of `WIDTH` bits, least-significant beat first, and marks the final beat with `out_last`. It sits at the transmit end of a narrow link, downstream of the team's pipeline-register stages. Both ports follow the same valid/ready handshake as the rest of the stream fabric. It sustains full narrow-side throughput, with no bubble between words.

---
 rtl/stream_serializer.sv | 69 ++++++
 tb/tb_stream_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer.sv
// Width-down converter: one WIDTH*RATIO word in, RATIO narrow beats out (LS beat first).
// Holds one word; a last-beat transfer and a new accept may coincide for bubble-free streaming.
module stream_serializer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH*RATIO-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  logic [WIDTH*RATIO-1:0] word_q;
  logic [CW-1:0]          cnt_q;
  logic                   valid_q;
  logic                   beat_xfer;
  logic                   word_accept;

  logic [WIDTH-1:0] beats [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_beat
      assign beats[gi] = word_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    out_data = beats[0];
    for (int k = 1; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) out_data = beats[k];
    end
  end

  assign out_valid   = valid_q;
  assign out_last    = valid_q && (cnt_q == LAST_IDX);
  // out_ready only reaches in_ready, and only on the last beat
  assign in_ready    = !valid_q || (out_ready && out_last);
  assign beat_xfer   = valid_q && out_ready;
  assign word_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (word_accept) begin
      word_q  <= in_data;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (beat_xfer) begin
      if (out_last) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: RATIO=4 and RATIO=1 instances checked against a beat scoreboard.
module tb_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data4;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic [7:0]  out_data4;
  logic [7:0]  in_data1, out_data1;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      sb4[$];
  logic [7:0] sb1[$];

  logic       obs_valid, obs_last, obs_in_ready;
  logic [7:0] obs_data;
  logic [1:0] obs_cnt;
  logic       exp_valid, exp_last, exp_in_ready;
  logic [7:0] exp_data;

  stream_serializer #(.WIDTH(8), .RATIO(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_last(out_last4)
  );

  stream_serializer #(.WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
  );

  // Drive one cycle on the RATIO=4 instance, sample outputs, then advance the scoreboard.
  task automatic cycle4(input bit iv, input logic [31:0] id, input bit ordy);
    beat_t b;
    @(negedge clk);
    in_valid4 = iv; in_data4 = id; out_ready4 = ordy;
    #1;
    obs_valid = out_valid4; obs_data = out_data4; obs_last = out_last4;
    obs_in_ready = in_ready4; obs_cnt = dut4.cnt_q;
    exp_valid = (sb4.size() != 0);
    exp_data  = exp_valid ? sb4[0].data : 8'h00;
    exp_last  = exp_valid ? sb4[0].last : 1'b0;
    exp_in_ready = !exp_valid || (ordy && exp_last);
    @(posedge clk);
    if (exp_valid && ordy) void'(sb4.pop_front());
    if (iv && exp_in_ready) begin
      for (int k = 0; k < 4; k++) begin
        b.data = id[k*8 +: 8];
        b.last = (k == 3);
        sb4.push_back(b);
      end
    end
  endtask

  task automatic cycle1(input bit iv, input logic [7:0] id, input bit ordy);
    @(negedge clk);
    in_valid1 = iv; in_data1 = id; out_ready1 = ordy;
    #1;
    obs_valid = out_valid1; obs_data = out_data1; obs_last = out_last1;
    obs_in_ready = in_ready1;
    exp_valid = (sb1.size() != 0);
    exp_data  = exp_valid ? sb1[0] : 8'h00;
    exp_last  = exp_valid;
    exp_in_ready = !exp_valid || ordy;
    @(posedge clk);
    if (exp_valid && ordy) void'(sb1.pop_front());
    if (iv && exp_in_ready) sb1.push_back(id);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid4 got=%b exp=0", out_valid4); end
    checks++; if (out_data4 !== 8'h00) begin failures++; $display("FAIL reset_out_data4 got=%h exp=00", out_data4); end
    checks++; if (out_last4 !== 1'b0) begin failures++; $display("FAIL reset_out_last4 got=%b exp=0", out_last4); end
    checks++; if (in_ready4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready4 got=%b exp=1", in_ready4); end
    checks++; if (out_last1 !== 1'b0) begin failures++; $display("FAIL reset_out_last1 got=%b exp=0", out_last1); end
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready1 got=%b exp=1", in_ready1); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle4(1'b0, 32'h0, 1'b1);
    checks++; if (obs_valid !== 1'b0 || obs_in_ready !== 1'b1)
      begin failures++; $display("FAIL post_reset_idle got valid=%b in_ready=%b exp valid=0 in_ready=1", obs_valid, obs_in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single_word;
    logic [7:0] eb;
    cycle4(1'b1, 32'h44332211, 1'b1);
    checks++; if (obs_in_ready !== 1'b1) begin failures++; $display("FAIL single_accept in_ready got=%b exp=1", obs_in_ready); end
    for (int i = 0; i < 4; i++) begin
      eb = 8'(8'h11 * (i + 1));
      cycle4(1'b0, 32'h0, 1'b1);
      checks++; if (obs_valid !== 1'b1 || obs_data !== eb)
        begin failures++; $display("FAIL single_beat%0d got valid=%b data=%h exp valid=1 data=%h", i, obs_valid, obs_data, eb); end
      checks++; if (obs_last !== (i == 3))
        begin failures++; $display("FAIL single_last%0d got=%b exp=%b", i, obs_last, (i == 3)); end
      checks++; if (obs_in_ready !== (i == 3))
        begin failures++; $display("FAIL single_in_ready%0d got=%b exp=%b", i, obs_in_ready, (i == 3)); end
      $display("single beat %0d data=%h last=%b", i, obs_data, obs_last);
    end
    cycle4(1'b0, 32'h0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL single_drained got valid=%b exp=0", obs_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [2];
    int idx = 0;
    int lasts = 0;
    logic [7:0] eb;
    w[0] = 32'h44332211; w[1] = 32'h88776655;
    for (int c = 0; c < 10; c++) begin
      cycle4(idx < 2, (idx < 2) ? w[idx] : 32'h0, 1'b1);
      if (idx < 2 && exp_in_ready) idx++;
      if (obs_valid && obs_last) lasts++;
      if (c >= 1 && c <= 8) begin
        eb = 8'(8'h11 * c);
        checks++; if (obs_valid !== 1'b1 || obs_data !== eb)
          begin failures++; $display("FAIL b2b_beat%0d got valid=%b data=%h exp valid=1 data=%h", c, obs_valid, obs_data, eb); end
        $display("b2b cycle %0d data=%h last=%b in_ready=%b", c, obs_data, obs_last, obs_in_ready);
      end
      if (c == 4) begin
        checks++; if (obs_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_on_44 got=%b exp=1", obs_in_ready); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (obs_in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_busy%0d got=%b exp=0", c, obs_in_ready); end
      end
    end
    checks++; if (lasts != 2) begin failures++; $display("FAIL b2b_last_count got=%0d exp=2", lasts); end
  endtask

  task automatic test_backpressure;
    cycle4(1'b1, 32'h44332211, 1'b1);
    cycle4(1'b0, 32'h0, 1'b1);
    cycle4(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle4(1'b1, 32'hCAFEF00D, 1'b0);
      checks++; if (obs_valid !== 1'b1 || obs_data !== 8'h33 || obs_cnt !== 2'd2)
        begin failures++; $display("FAIL bp_hold%0d got valid=%b data=%h cnt=%0d exp valid=1 data=33 cnt=2", i, obs_valid, obs_data, obs_cnt); end
      checks++; if (obs_in_ready !== 1'b0 || obs_last !== 1'b0)
        begin failures++; $display("FAIL bp_ctrl%0d got in_ready=%b last=%b exp 0 0", i, obs_in_ready, obs_last); end
      $display("bp stall %0d data=%h cnt=%0d", i, obs_data, obs_cnt);
    end
    cycle4(1'b0, 32'h0, 1'b1);
    checks++; if (obs_data !== 8'h33 || obs_in_ready !== 1'b0)
      begin failures++; $display("FAIL bp_resume33 got data=%h in_ready=%b exp data=33 in_ready=0", obs_data, obs_in_ready); end
    cycle4(1'b0, 32'h0, 1'b1);
    checks++; if (obs_valid !== 1'b1 || obs_data !== 8'h44 || obs_last !== 1'b1)
      begin failures++; $display("FAIL bp_resume44 got valid=%b data=%h last=%b exp 1 44 1", obs_valid, obs_data, obs_last); end
    cycle4(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid_word;
    cycle4(1'b1, 32'h44332211, 1'b1);
    cycle4(1'b0, 32'h0, 1'b1);
    cycle4(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1)
      begin failures++; $display("FAIL midrst_immediate got valid=%b in_ready=%b exp 0 1", out_valid4, in_ready4); end
    $display("mid-word reset asserted valid=%b in_ready=%b", out_valid4, in_ready4);
    sb4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle4(1'b1, 32'hDDCCBBAA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle4(1'b0, 32'h0, 1'b1);
      checks++; if (obs_valid !== exp_valid || obs_data !== exp_data || obs_last !== exp_last)
        begin failures++; $display("FAIL midrst_beat%0d got %b %h %b exp %b %h %b", i, obs_valid, obs_data, obs_last, exp_valid, exp_data, exp_last); end
      if (i == 0) begin
        checks++; if (obs_data !== 8'hAA) begin failures++; $display("FAIL midrst_first got=%h exp=aa", obs_data); end
      end
    end
  endtask

  task automatic test_ratio1;
    int idx = 0;
    int got = 0;
    int n = 0;
    bit ordy;
    while (got < 3 && n < 200) begin
      ordy = ($urandom_range(0, 2) != 0);
      cycle1(idx < 3, 8'(idx + 1), ordy);
      n++;
      checks++; if (obs_valid !== exp_valid || obs_in_ready !== exp_in_ready || obs_last !== exp_last)
        begin failures++; $display("FAIL r1_ctrl got valid=%b in_ready=%b last=%b exp %b %b %b", obs_valid, obs_in_ready, obs_last, exp_valid, exp_in_ready, exp_last); end
      if (obs_valid && ordy) begin
        checks++; if (obs_data !== 8'(got + 1))
          begin failures++; $display("FAIL r1_order got=%h exp=%h", obs_data, 8'(got + 1)); end
        $display("r1 beat data=%h last=%b", obs_data, obs_last);
        got++;
      end
      if (idx < 3 && exp_in_ready) idx++;
    end
    checks++; if (got != 3) begin failures++; $display("FAIL r1_count got=%0d exp=3", got); end
  endtask

  task automatic test_random_soak;
    logic [31:0] wq[$];
    logic [31:0] asm_word = '0;
    logic [31:0] pword = '0;
    bit pending = 0;
    bit ordy;
    int bi = 0;
    int lasts = 0;
    int accepts = 0;
    for (int c = 0; c < 10020; c++) begin
      if (!pending && c < 10000 && $urandom_range(0, 2) != 0) begin
        pending = 1; pword = $urandom;
      end
      ordy = (c >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle4(pending, pending ? pword : 32'h0, ordy);
      checks++; if (obs_valid !== exp_valid || obs_in_ready !== exp_in_ready)
        begin failures++; $display("FAIL soak_ctrl c=%0d got valid=%b in_ready=%b exp %b %b", c, obs_valid, obs_in_ready, exp_valid, exp_in_ready); end
      if (exp_valid) begin
        checks++; if (obs_data !== exp_data || obs_last !== exp_last)
          begin failures++; $display("FAIL soak_beat c=%0d got data=%h last=%b exp %h %b", c, obs_data, obs_last, exp_data, exp_last); end
      end
      if (pending && exp_in_ready) begin
        wq.push_back(pword); pending = 0; accepts++;
      end
      if (obs_valid && ordy) begin
        asm_word[bi*8 +: 8] = obs_data;
        if (obs_last) begin
          lasts++;
          checks++; if (wq.size() == 0 || asm_word !== wq[0])
            begin failures++; $display("FAIL soak_word got=%h exp=%h", asm_word, (wq.size() != 0) ? wq[0] : 32'h0); end
          if (wq.size() != 0) void'(wq.pop_front());
          bi = 0;
        end else begin
          bi = (bi + 1) % 4;
        end
      end
    end
    checks++; if (lasts != accepts || wq.size() != 0)
      begin failures++; $display("FAIL soak_totals got lasts=%0d left=%0d exp lasts=%0d left=0", lasts, wq.size(), accepts); end
    $display("soak words=%0d lasts=%0d", accepts, lasts);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_ratio1();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
